// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light generator/monitor pair: light codes,
// monitor state encodings, error event kinds and the phase-order helper.
package traffic_pkg;

    localparam logic [1:0] RED     = 2'b00;
    localparam logic [1:0] GREEN   = 2'b01;
    localparam logic [1:0] YELLOW  = 2'b10;
    localparam logic [1:0] ILLEGAL = 2'b11;

    localparam logic [0:0] ACQUIRE = 1'b0;
    localparam logic [0:0] TRACK   = 1'b1;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_CODE  = 2'd1,
        ERR_SEQ   = 2'd2,
        ERR_DWELL = 2'd3
    } err_e;

    typedef struct packed {
        logic red;
        logic green;
        logic yellow;
    } lamp_t;

    // The illegal code has no successor; callers screen it out first.
    function automatic logic [1:0] nextPhase(input logic [1:0] code);
        logic [1:0] nxt;
        case (code)
            RED:     nxt = GREEN;
            GREEN:   nxt = YELLOW;
            YELLOW:  nxt = RED;
            default: nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Bundle between the light generator (master) and the lamp driver / sequence
// monitor (slave): the light code forward, lamp drives and status back.
interface traffic_light_monitor_if #(
    parameter int ERR_W = 8,
    parameter int CNT_W = 16
);
    logic [1:0]       light;
    logic             lamp_red;
    logic             lamp_green;
    logic             lamp_yellow;
    logic             locked;
    logic             code_err;
    logic             seq_err;
    logic             dwell_err;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output light,
        input  lamp_red, lamp_green, lamp_yellow, locked,
        input  code_err, seq_err, dwell_err, err_count, cycle_count
    );

    modport slave (
        input  light,
        output lamp_red, lamp_green, lamp_yellow, locked,
        output code_err, seq_err, dwell_err, err_count, cycle_count
    );
endinterface

// File: rtl/traffic_light_decode.sv
// Combinational decode of the 2-bit light code into one-hot lamp drives;
// the illegal code leaves every lamp dark.
module traffic_light_decode
    import traffic_pkg::*;
(
    input  logic [1:0] light_i,
    output lamp_t      lamps_o
);

    always_comb begin
        lamps_o = '0;
        case (light_i)
            RED:     lamps_o.red    = 1'b1;
            GREEN:   lamps_o.green  = 1'b1;
            YELLOW:  lamps_o.yellow = 1'b1;
            default: lamps_o        = '0;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Lamp driver and RED->GREEN->YELLOW sequence/dwell monitor for the generator's
// light code. Define TRAFFIC_MON_STICKY_EN to hold error flags until reset.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int DW_W      = 8,
    parameter int ERR_W     = 8,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    traffic_light_monitor_if.slave mon
);

    localparam logic [DW_W-1:0] DWELL_ONE = DW_W'(1);
    localparam logic [DW_W-1:0] DWELL_MIN = DW_W'(MIN_DWELL);
    localparam logic [DW_W-1:0] DWELL_CAP = DW_W'(MAX_DWELL + 1);

    lamp_t            lampsDec;
    lamp_t            lamps_q;
    logic [0:0]       state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    err_e             evt_d;
    logic             cycleInc;
    logic             codeErr_q, seqErr_q, dwellErr_q;
    logic [ERR_W-1:0] errCount_q;
    logic [CNT_W-1:0] cycleCount_q;

    traffic_light_decode u_decode (
        .light_i (mon.light),
        .lamps_o (lampsDec)
    );

    // Phase tracking; the if/else chain fixes the error priority so only one
    // event kind can be raised per sample.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        dwell_d  = dwell_q;
        evt_d    = ERR_NONE;
        cycleInc = 1'b0;
        if (state_q == ACQUIRE) begin
            if (mon.light == ILLEGAL) begin
                evt_d = ERR_CODE;
            end else if (mon.light == RED) begin
                state_d = TRACK;
                phase_d = RED;
                dwell_d = DWELL_ONE;
            end
        end else begin
            if (mon.light == ILLEGAL) begin
                evt_d   = ERR_CODE;
                state_d = ACQUIRE;
                dwell_d = '0;
            end else if (mon.light == phase_q) begin
                if (dwell_q != DWELL_CAP) begin
                    dwell_d = dwell_q + DWELL_ONE;
                    if (dwell_d == DWELL_CAP) begin
                        evt_d = ERR_DWELL;
                    end
                end
            end else if (mon.light == nextPhase(phase_q)) begin
                if (dwell_q < DWELL_MIN) begin
                    evt_d = ERR_DWELL;
                end
                cycleInc = (phase_q == YELLOW);
                phase_d  = mon.light;
                dwell_d  = DWELL_ONE;
            end else begin
                evt_d   = ERR_SEQ;
                state_d = ACQUIRE;
                dwell_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lamps_q <= '0;
            state_q <= ACQUIRE;
            phase_q <= RED;
            dwell_q <= '0;
        end else begin
            lamps_q <= lampsDec;
            state_q <= state_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
        end
    end

    // Error flags: one-cycle pulses by default, latched until reset when sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            codeErr_q  <= 1'b0;
            seqErr_q   <= 1'b0;
            dwellErr_q <= 1'b0;
        end else begin
`ifdef TRAFFIC_MON_STICKY_EN
            codeErr_q  <= codeErr_q  | (evt_d == ERR_CODE);
            seqErr_q   <= seqErr_q   | (evt_d == ERR_SEQ);
            dwellErr_q <= dwellErr_q | (evt_d == ERR_DWELL);
`else
            codeErr_q  <= (evt_d == ERR_CODE);
            seqErr_q   <= (evt_d == ERR_SEQ);
            dwellErr_q <= (evt_d == ERR_DWELL);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errCount_q   <= '0;
            cycleCount_q <= '0;
        end else begin
            if ((evt_d != ERR_NONE) && (errCount_q != '1)) begin
                errCount_q <= errCount_q + ERR_W'(1);
            end
            if (cycleInc) begin
                cycleCount_q <= cycleCount_q + CNT_W'(1);
            end
        end
    end

    assign mon.lamp_red    = lamps_q.red;
    assign mon.lamp_green  = lamps_q.green;
    assign mon.lamp_yellow = lamps_q.yellow;
    assign mon.locked      = (state_q == TRACK);
    assign mon.code_err    = codeErr_q;
    assign mon.seq_err     = seqErr_q;
    assign mon.dwell_err   = dwellErr_q;
    assign mon.err_count   = errCount_q;
    assign mon.cycle_count = cycleCount_q;

endmodule
